// File: rtl/count_event_logger_if.sv
// Read-side handshake bundle of the count event logger.
// The logger drives valid/data through master; the consumer drives ready through slave.
interface count_event_logger_if #(
    parameter int WIDTH = 5
);
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH+1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/count_event_logger.sv
// Watches a counter value and sorts each change into START/STEP/WRAP/JUMP.
// Each event goes into a small FIFO; wrap pulse and overflow status are reported beside it.
module count_event_logger #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    parameter int DROPW = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         count,
    input  logic                     sample_en,
    input  logic                     clear,
    count_event_logger_if.master     rd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wrap_pulse,
    output logic                     overflow,
    output logic [DROPW-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    localparam logic [1:0] CODE_START = 2'b00;
    localparam logic [1:0] CODE_STEP  = 2'b01;
    localparam logic [1:0] CODE_WRAP  = 2'b10;
    localparam logic [1:0] CODE_JUMP  = 2'b11;

    typedef enum logic {
        PRIME,
        TRACK
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_prev;
    logic             w_event;
    logic [1:0]       w_code;

    logic [WIDTH+1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic             r_wrapPulse;
    logic             r_overflow;
    logic [DROPW-1:0] r_dropCount;

    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_pushAccept;
    logic             w_drop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= PRIME;
        end else if (clear) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Classification is purely against the last logged value, so the push can happen on this same edge.
    always_comb begin
        w_nextState = r_state;
        w_event     = 1'b0;
        w_code      = CODE_START;
        case (r_state)
            PRIME: begin
                if (sample_en) begin
                    w_event     = 1'b1;
                    w_code      = CODE_START;
                    w_nextState = TRACK;
                end
            end
            TRACK: begin
                if (sample_en && (count != r_prev)) begin
                    w_event = 1'b1;
                    if ((r_prev == '1) && (count == '0)) begin
                        w_code = CODE_WRAP;
                    end else if ((r_prev != '1) && (count == r_prev + 1'b1)) begin
                        w_code = CODE_STEP;
                    end else begin
                        w_code = CODE_JUMP;
                    end
                end
            end
            default: begin
                w_nextState = PRIME;
            end
        endcase
    end

    assign w_valid      = (r_level != '0);
    assign w_full       = (r_level == FULL_LEVEL);
    assign w_pop        = w_valid && rd.rd_ready;
    assign w_pushAccept = w_event && (!w_full || w_pop);
    assign w_drop       = w_event && w_full && !w_pop;

    // prev follows every logged event, dropped or not, and is left alone by clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
        end else if (!clear && w_event) begin
            r_prev <= count;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && w_pushAccept) begin
            r_mem[r_wrPtr] <= {w_code, count};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_pushAccept) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushAccept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // The wrap pulse reflects the classification, so it fires even when the WRAP entry is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrapPulse <= 1'b0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else if (clear) begin
            r_wrapPulse <= 1'b0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else begin
            r_wrapPulse <= w_event && (w_code == CODE_WRAP);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCount != '1) begin
                    r_dropCount <= r_dropCount + 1'b1;
                end
            end
        end
    end

    assign rd.rd_valid = w_valid;
    assign rd.rd_data  = w_valid ? r_mem[r_rdPtr] : '0;
    assign level       = r_level;
    assign wrap_pulse  = r_wrapPulse;
    assign overflow    = r_overflow;
    assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_count_event_logger.sv
// Directed scenarios for count_event_logger; every expected entry is hand-computed as {code, count}.
module tb_count_event_logger;

    logic       clock;
    logic       reset;
    logic [4:0] count;
    logic       sample_en;
    logic       clear;
    logic [3:0] level;
    logic       wrap_pulse;
    logic       overflow;
    logic [7:0] drop_count;

    int total;
    int bad;

    count_event_logger_if #(.WIDTH(5)) rdIf ();

    count_event_logger #(
        .WIDTH(5),
        .DEPTH(8),
        .DROPW(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .count      (count),
        .sample_en  (sample_en),
        .clear      (clear),
        .rd         (rdIf.master),
        .level      (level),
        .wrap_pulse (wrap_pulse),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        count        = '0;
        sample_en    = 1'b0;
        clear        = 1'b0;
        rdIf.rd_ready = 1'b0;
        reset        = 1'b1;
        tick();
        reset        = 1'b0;
    endtask

    task automatic sampleCount(input logic [4:0] v);
        count     = v;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        total++;
        if (rdIf.rd_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 ||
            drop_count !== 8'd0 || wrap_pulse !== 1'b0 || rdIf.rd_data !== 7'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: valid=%0b level=%0d ovf=%0b drops=%0d wrap=%0b data=%0d expected all 0",
                     rdIf.rd_valid, level, overflow, drop_count, wrap_pulse, rdIf.rd_data);
        end
    endtask

    task automatic test_steps();
        logic [6:0] exp [3] = '{7'd3, 7'd36, 7'd37};
        doReset();
        sampleCount(5'd3);
        total++;
        if (rdIf.rd_valid !== 1'b1 || rdIf.rd_data !== 7'd3) begin
            bad++;
            $display("[TB] FAIL steps_latency: valid=%0b data=%0d expected valid=1 data=3", rdIf.rd_valid, rdIf.rd_data);
        end
        sampleCount(5'd4);
        sampleCount(5'd5);
        total++;
        if (level !== 4'd3) begin
            bad++;
            $display("[TB] FAIL steps_level: got %0d expected 3", level);
        end
        rdIf.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdIf.rd_valid !== 1'b1 || rdIf.rd_data !== exp[i]) begin
                bad++;
                $display("[TB] FAIL steps_entry%0d: valid=%0b data=%0d expected valid=1 data=%0d",
                         i, rdIf.rd_valid, rdIf.rd_data, exp[i]);
            end
            tick();
        end
        rdIf.rd_ready = 1'b0;
        total++;
        if (rdIf.rd_valid !== 1'b0 || level !== 4'd0) begin
            bad++;
            $display("[TB] FAIL steps_drained: valid=%0b level=%0d expected 0 0", rdIf.rd_valid, level);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] exp [3] = '{7'd30, 7'd63, 7'd64};
        doReset();
        sampleCount(5'd30);
        sampleCount(5'd31);
        total++;
        if (wrap_pulse !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_early: got %0b expected 0", wrap_pulse);
        end
        sampleCount(5'd0);
        total++;
        if (wrap_pulse !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wrap_pulse: got %0b expected 1", wrap_pulse);
        end
        tick();
        total++;
        if (wrap_pulse !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_pulse_width: got %0b expected 0", wrap_pulse);
        end
        rdIf.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdIf.rd_valid !== 1'b1 || rdIf.rd_data !== exp[i]) begin
                bad++;
                $display("[TB] FAIL wrap_entry%0d: valid=%0b data=%0d expected valid=1 data=%0d",
                         i, rdIf.rd_valid, rdIf.rd_data, exp[i]);
            end
            tick();
        end
        rdIf.rd_ready = 1'b0;
    endtask

    task automatic test_hold_jump();
        logic [6:0] exp [3] = '{7'd7, 7'd108, 7'd96};
        doReset();
        sampleCount(5'd7);
        sampleCount(5'd7);
        sampleCount(5'd7);
        sampleCount(5'd12);
        sampleCount(5'd0);
        total++;
        if (level !== 4'd3) begin
            bad++;
            $display("[TB] FAIL hold_level: got %0d expected 3", level);
        end
        rdIf.rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdIf.rd_valid !== 1'b1 || rdIf.rd_data !== exp[i]) begin
                bad++;
                $display("[TB] FAIL hold_entry%0d: valid=%0b data=%0d expected valid=1 data=%0d",
                         i, rdIf.rd_valid, rdIf.rd_data, exp[i]);
            end
            tick();
        end
        rdIf.rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [6:0] exp [8] = '{7'd33, 7'd34, 7'd35, 7'd36, 7'd37, 7'd38, 7'd39, 7'd42};
        doReset();
        for (int v = 0; v < 10; v++) begin
            sampleCount(5'(v));
        end
        total++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2 || rdIf.rd_data !== 7'd0) begin
            bad++;
            $display("[TB] FAIL ovf_status: level=%0d ovf=%0b drops=%0d head=%0d expected 8 1 2 0",
                     level, overflow, drop_count, rdIf.rd_data);
        end
        rdIf.rd_ready = 1'b1;
        sampleCount(5'd10);
        rdIf.rd_ready = 1'b0;
        total++;
        if (level !== 4'd8 || drop_count !== 8'd2 || rdIf.rd_data !== 7'd33) begin
            bad++;
            $display("[TB] FAIL ovf_pop_push: level=%0d drops=%0d head=%0d expected 8 2 33",
                     level, drop_count, rdIf.rd_data);
        end
        rdIf.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (rdIf.rd_valid !== 1'b1 || rdIf.rd_data !== exp[i]) begin
                bad++;
                $display("[TB] FAIL ovf_entry%0d: valid=%0b data=%0d expected valid=1 data=%0d",
                         i, rdIf.rd_valid, rdIf.rd_data, exp[i]);
            end
            tick();
        end
        rdIf.rd_ready = 1'b0;
        total++;
        if (rdIf.rd_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_sticky: valid=%0b ovf=%0b expected 0 1", rdIf.rd_valid, overflow);
        end
    endtask

    task automatic test_sample_en();
        logic [6:0] exp [2] = '{7'd2, 7'd35};
        doReset();
        sampleCount(5'd2);
        count = 5'd9;
        tick();
        sampleCount(5'd3);
        total++;
        if (level !== 4'd2) begin
            bad++;
            $display("[TB] FAIL en_level: got %0d expected 2", level);
        end
        rdIf.rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (rdIf.rd_valid !== 1'b1 || rdIf.rd_data !== exp[i]) begin
                bad++;
                $display("[TB] FAIL en_entry%0d: valid=%0b data=%0d expected valid=1 data=%0d",
                         i, rdIf.rd_valid, rdIf.rd_data, exp[i]);
            end
            tick();
        end
        rdIf.rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        doReset();
        for (int v = 0; v < 9; v++) begin
            sampleCount(5'(v));
        end
        rdIf.rd_ready = 1'b1;
        repeat (4) tick();
        rdIf.rd_ready = 1'b0;
        total++;
        if (level !== 4'd4 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL areset_setup: level=%0d ovf=%0b expected 4 1", level, overflow);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (rdIf.rd_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL areset_immediate: valid=%0b level=%0d ovf=%0b drops=%0d expected all 0",
                     rdIf.rd_valid, level, overflow, drop_count);
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_clear();
        doReset();
        for (int v = 0; v < 9; v++) begin
            sampleCount(5'(v));
        end
        clear = 1'b1;
        sampleCount(5'd9);
        clear = 1'b0;
        total++;
        if (rdIf.rd_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL clear_flush: valid=%0b level=%0d ovf=%0b drops=%0d expected 0 0 0 0",
                     rdIf.rd_valid, level, overflow, drop_count);
        end
        sampleCount(5'd20);
        total++;
        if (rdIf.rd_valid !== 1'b1 || rdIf.rd_data !== 7'd20 || level !== 4'd1) begin
            bad++;
            $display("[TB] FAIL clear_restart: valid=%0b data=%0d level=%0d expected 1 20 1",
                     rdIf.rd_valid, rdIf.rd_data, level);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_steps();
        test_wrap();
        test_hold_jump();
        test_overflow();
        test_sample_en();
        test_async_reset();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
